// File: rtl/text_mode_renderer_if.sv
// Host-side bus of the text renderer: character RAM writes and cursor loads.
//
// Signals
//   wr_en       character RAM write strobe
//   wr_addr     row*COLS+col of the cell to write
//   wr_data     [15:8] glyph code, [7:4] background index, [3:0] foreground index
//   cursor_wr   load strobe for the cursor registers
//   cursor_col  cursor column
//   cursor_row  cursor row
//   cursor_en   cursor enable
//
// Handshake: both strobes are single-cycle commands sampled on the rising
// pixel clock edge. The renderer is always ready and there is no valid/ready
// pair: a strobe high at an edge is one complete command. The data fields
// only need to be stable at edges where their strobe is high.
`timescale 1ns/1ps
interface text_mode_renderer_if #(
    parameter int ADDR_W = 12
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cursor_wr;
    logic [6:0]        cursor_col;
    logic [5:0]        cursor_row;
    logic              cursor_en;

    modport master (
        output wr_en, wr_addr, wr_data,
        output cursor_wr, cursor_col, cursor_row, cursor_en
    );

    modport slave (
        input wr_en, wr_addr, wr_data,
        input cursor_wr, cursor_col, cursor_row, cursor_en
    );
endinterface

// File: rtl/text_mode_renderer.sv
// Character-cell text renderer, 8x16 pixel cells, fed by the VGA sync
// generator's registered outputs.
//
// Ports
//   in_vga_clk              pixel clock, all logic on posedge
//   in_reset                asynchronous, active-high reset
//   in_pixel_x/in_pixel_y   current pixel position from the sync generator
//   in_blank_n              1 = active video
//   in_h_sync/in_v_sync     active-low syncs
//   host                    character RAM writes and cursor loads
//   out_font_addr           {glyph, glyph_row} to the external synchronous font ROM
//   in_font_data            ROM row, valid one cycle after out_font_addr; bit 7 is leftmost
//   out_red/green/blue      8-bit colour channels
//   out_blank_n/h/v_sync    sideband delayed to line up with the colour
//
// Everything sampled at edge N appears on the outputs after edge N+3:
//   S1 (N)   cell address, in-grid flag, cursor hit, sideband
//   S2 (N+1) character RAM registered read, drives the font ROM address
//   S3 (N+2) ROM registers its row, attribute byte moves along
//   S4 (N+3) pixel select, palette lookup, blanking
`timescale 1ns/1ps
module text_mode_renderer #(
    parameter int COLS         = 100,
    parameter int ROWS         = 37,
    parameter int ADDR_W       = 12,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                 in_vga_clk,
    input  logic                 in_reset,
    input  logic [9:0]           in_pixel_x,
    input  logic [9:0]           in_pixel_y,
    input  logic                 in_blank_n,
    input  logic                 in_h_sync,
    input  logic                 in_v_sync,
    text_mode_renderer_if.slave  host,
    output logic [11:0]          out_font_addr,
    input  logic [7:0]           in_font_data,
    output logic [7:0]           out_red,
    output logic [7:0]           out_green,
    output logic [7:0]           out_blue,
    output logic                 out_blank_n,
    output logic                 out_h_sync,
    output logic                 out_v_sync
);
    localparam int DEPTH   = COLS * ROWS;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // CGA palette, idx = {i,r,g,b}. Index 6 is brown rather than dark yellow.
    function automatic logic [23:0] cga_rgb(input logic [3:0] idx);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        hi = idx[3] ? 8'hFF : 8'hAA;
        lo = idx[3] ? 8'h55 : 8'h00;
        r  = idx[2] ? hi : lo;
        g  = idx[1] ? hi : lo;
        b  = idx[0] ? hi : lo;
        if (idx == 4'd6) begin
            g = 8'h55;
        end
        return {r, g, b};
    endfunction

    // Character/attribute store. Not reset: contents survive in_reset.
    logic [15:0] ram_mem [DEPTH];

    // Cursor and blink state
    logic [6:0]         cursor_col_q, cursor_col_d;
    logic [5:0]         cursor_row_q, cursor_row_d;
    logic               cursor_en_q,  cursor_en_d;
    logic               vs_prev_q,    vs_prev_d;
    logic [BLINK_W-1:0] blink_cnt_q,  blink_cnt_d;
    logic               phase_q,      phase_d;

    // S1
    logic [2:0]         s1_x_q,       s1_x_d;
    logic [3:0]         s1_y_q,       s1_y_d;
    logic               s1_blank_n_q, s1_blank_n_d;
    logic               s1_hs_q,      s1_hs_d;
    logic               s1_vs_q,      s1_vs_d;
    logic [ADDR_W-1:0]  s1_addr_q,    s1_addr_d;
    logic               s1_grid_q,    s1_grid_d;
    logic               s1_cur_q,     s1_cur_d;

    // S2
    logic [15:0]        s2_word_q,    s2_word_d;
    logic [2:0]         s2_x_q,       s2_x_d;
    logic [3:0]         s2_y_q,       s2_y_d;
    logic               s2_blank_n_q, s2_blank_n_d;
    logic               s2_hs_q,      s2_hs_d;
    logic               s2_vs_q,      s2_vs_d;
    logic               s2_grid_q,    s2_grid_d;
    logic               s2_cur_q,     s2_cur_d;

    // S3
    logic [7:0]         s3_attr_q,    s3_attr_d;
    logic [2:0]         s3_x_q,       s3_x_d;
    logic               s3_blank_n_q, s3_blank_n_d;
    logic               s3_hs_q,      s3_hs_d;
    logic               s3_vs_q,      s3_vs_d;
    logic               s3_grid_q,    s3_grid_d;
    logic               s3_cur_q,     s3_cur_d;

    // S4 (output registers)
    logic [23:0]        rgb_q,        rgb_d;
    logic               o_blank_n_q,  o_blank_n_d;
    logic               o_hs_q,       o_hs_d;
    logic               o_vs_q,       o_vs_d;

    // Combinational helpers
    logic [6:0]  cell_col;
    logic [5:0]  cell_row;
    logic        cell_in_grid;
    logic [31:0] cell_lin;
    logic        ram_we;
    logic        font_bit;
    logic        pixel_on;
    logic [3:0]  colour_idx;

    always_comb begin
        // ---------------- cursor registers ----------------
        cursor_col_d = cursor_col_q;
        cursor_row_d = cursor_row_q;
        cursor_en_d  = cursor_en_q;
        if (host.cursor_wr) begin
            cursor_col_d = host.cursor_col;
            cursor_row_d = host.cursor_row;
            cursor_en_d  = host.cursor_en;
        end

        // ---------------- blink on v_sync falling edge ----------------
        vs_prev_d   = in_v_sync;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (vs_prev_q && !in_v_sync) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // ---------------- host write ----------------
        ram_we = host.wr_en && (32'(host.wr_addr) < 32'(DEPTH));

        // ---------------- S1 ----------------
        cell_col     = in_pixel_x[9:3];
        cell_row     = in_pixel_y[9:4];
        cell_in_grid = (32'(cell_col) < 32'(COLS)) && (32'(cell_row) < 32'(ROWS));
        cell_lin     = 32'(cell_row) * 32'(COLS) + 32'(cell_col);

        s1_x_d       = in_pixel_x[2:0];
        s1_y_d       = in_pixel_y[3:0];
        s1_blank_n_d = in_blank_n;
        s1_hs_d      = in_h_sync;
        s1_vs_d      = in_v_sync;
        s1_grid_d    = cell_in_grid;
        // Off-grid cells read address 0; their colour is forced to black later.
        s1_addr_d    = cell_in_grid ? cell_lin[ADDR_W-1:0] : '0;
        // In-grid qualification makes out-of-range cursor positions inert.
        s1_cur_d     = cursor_en_q && cell_in_grid &&
                       (cell_col == cursor_col_q) && (cell_row == cursor_row_q) &&
                       (in_pixel_y[3:0] >= 4'd14);

        // ---------------- S2 ----------------
        // Read before the write at the same edge lands: same-address
        // collisions return the old word.
        s2_word_d    = ram_mem[s1_addr_q];
        s2_x_d       = s1_x_q;
        s2_y_d       = s1_y_q;
        s2_blank_n_d = s1_blank_n_q;
        s2_hs_d      = s1_hs_q;
        s2_vs_d      = s1_vs_q;
        s2_grid_d    = s1_grid_q;
        s2_cur_d     = s1_cur_q;

        // ---------------- S3 ----------------
        s3_attr_d    = s2_word_q[7:0];
        s3_x_d       = s2_x_q;
        s3_blank_n_d = s2_blank_n_q;
        s3_hs_d      = s2_hs_q;
        s3_vs_d      = s2_vs_q;
        s3_grid_d    = s2_grid_q;
        s3_cur_d     = s2_cur_q;

        // ---------------- S4 ----------------
        // in_font_data now holds the row addressed during S2.
        font_bit    = in_font_data[3'd7 - s3_x_q];
        pixel_on    = font_bit | (s3_cur_q & phase_q);
        colour_idx  = pixel_on ? s3_attr_q[3:0] : s3_attr_q[7:4];
        rgb_d       = (s3_blank_n_q && s3_grid_q) ? cga_rgb(colour_idx) : 24'h000000;
        o_blank_n_d = s3_blank_n_q;
        o_hs_d      = s3_hs_q;
        o_vs_d      = s3_vs_q;
    end

    always_ff @(posedge in_vga_clk) begin
        if (ram_we) begin
            ram_mem[host.wr_addr] <= host.wr_data;
        end
    end

    always_ff @(posedge in_vga_clk or posedge in_reset) begin
        if (in_reset) begin
            cursor_col_q <= '0;
            cursor_row_q <= '0;
            cursor_en_q  <= 1'b0;
            vs_prev_q    <= 1'b1;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b1;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_blank_n_q <= 1'b0;
            s1_hs_q      <= 1'b1;
            s1_vs_q      <= 1'b1;
            s1_addr_q    <= '0;
            s1_grid_q    <= 1'b0;
            s1_cur_q     <= 1'b0;
            s2_word_q    <= '0;
            s2_x_q       <= '0;
            s2_y_q       <= '0;
            s2_blank_n_q <= 1'b0;
            s2_hs_q      <= 1'b1;
            s2_vs_q      <= 1'b1;
            s2_grid_q    <= 1'b0;
            s2_cur_q     <= 1'b0;
            s3_attr_q    <= '0;
            s3_x_q       <= '0;
            s3_blank_n_q <= 1'b0;
            s3_hs_q      <= 1'b1;
            s3_vs_q      <= 1'b1;
            s3_grid_q    <= 1'b0;
            s3_cur_q     <= 1'b0;
            rgb_q        <= '0;
            o_blank_n_q  <= 1'b0;
            o_hs_q       <= 1'b1;
            o_vs_q       <= 1'b1;
        end else begin
            cursor_col_q <= cursor_col_d;
            cursor_row_q <= cursor_row_d;
            cursor_en_q  <= cursor_en_d;
            vs_prev_q    <= vs_prev_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_blank_n_q <= s1_blank_n_d;
            s1_hs_q      <= s1_hs_d;
            s1_vs_q      <= s1_vs_d;
            s1_addr_q    <= s1_addr_d;
            s1_grid_q    <= s1_grid_d;
            s1_cur_q     <= s1_cur_d;
            s2_word_q    <= s2_word_d;
            s2_x_q       <= s2_x_d;
            s2_y_q       <= s2_y_d;
            s2_blank_n_q <= s2_blank_n_d;
            s2_hs_q      <= s2_hs_d;
            s2_vs_q      <= s2_vs_d;
            s2_grid_q    <= s2_grid_d;
            s2_cur_q     <= s2_cur_d;
            s3_attr_q    <= s3_attr_d;
            s3_x_q       <= s3_x_d;
            s3_blank_n_q <= s3_blank_n_d;
            s3_hs_q      <= s3_hs_d;
            s3_vs_q      <= s3_vs_d;
            s3_grid_q    <= s3_grid_d;
            s3_cur_q     <= s3_cur_d;
            rgb_q        <= rgb_d;
            o_blank_n_q  <= o_blank_n_d;
            o_hs_q       <= o_hs_d;
            o_vs_q       <= o_vs_d;
        end
    end

    // Font address comes straight from S2 registers so the ROM sees it a
    // full cycle before S4 needs the data.
    assign out_font_addr = {s2_word_q[15:8], s2_y_q};
    assign out_red       = rgb_q[23:16];
    assign out_green     = rgb_q[15:8];
    assign out_blue      = rgb_q[7:0];
    assign out_blank_n   = o_blank_n_q;
    assign out_h_sync    = o_hs_q;
    assign out_v_sync    = o_vs_q;

endmodule
